// File: rtl/uart_pkg.sv
// uart_pkg: shared parity/state types and divisor helper for the UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  function automatic logic [31:0] calc_divisor(input logic [31:0] clock_frequency, input logic [31:0] baud_rate);
    return clock_frequency / baud_rate;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with registered full/empty/level and extra-MSB pointer wrap
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     we,
  output logic                     full,
  output logic [WIDTH-1:0]         dout,
  input  logic                     re,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  logic push, pop;
  assign push = we && !full;
  assign pop = re && !empty;
  assign wptr_n = wptr + LW'(push);
  assign rptr_n = rptr + LW'(pop);
  assign dout = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      level <= wptr_n - rptr_n;
      full <= wptr_n == {~rptr_n[AW], rptr_n[AW-1:0]};
      empty <= wptr_n == rptr_n;
    end
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with runtime parity/stop config; UART_TX_CTS_EN adds cts_n flow control
module uart_tx_fifo import uart_pkg::*; #(
  parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
  parameter int unsigned BAUD_RATE       = 32'd115200,
  parameter int unsigned WORD_WIDTH      = 32'd8,
  parameter int unsigned FIFO_DEPTH      = 32'd16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WORD_WIDTH-1:0]         din,
  input  logic                          we,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          busy,
  output logic                          txd
`ifdef UART_TX_CTS_EN
  ,
  input  logic                          cts_n
`endif
);
  localparam int unsigned DIVISOR = calc_divisor(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CW = $clog2(DIVISOR);
  localparam int BW = $clog2(WORD_WIDTH + 1);
  tx_state_t state, nxt;
  parity_t par, par_in;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [WORD_WIDTH-1:0] sh, dout;
  logic stop2, par_bit, empty, pop, wrap, last_bit, txd_c, cts_ok;
  uart_sync_fifo #(.WIDTH(int'(WORD_WIDTH)), .DEPTH(int'(FIFO_DEPTH))) fifo (
    .clk(clk), .rst(rst), .din(din), .we(we), .full(full),
    .dout(dout), .re(pop), .empty(empty), .level(level)
  );
`ifdef UART_TX_CTS_EN
  logic [1:0] cts_s;
  always_ff @(posedge clk or posedge rst)
    if (rst) cts_s <= 2'b11;
    else cts_s <= {cts_s[0], cts_n};
  assign cts_ok = !cts_s[1];
`else
  assign cts_ok = 1'b1;
`endif
  assign par_in = cfg_parity == 2'b11 ? PAR_NONE : parity_t'(cfg_parity);
  assign wrap = cnt == CW'(DIVISOR - 1);
  assign last_bit = bit_cnt == BW'(WORD_WIDTH - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    pop = 1'b0;
    txd_c = 1'b1;
    case (state)
      IDLE: begin
        pop = !empty && cts_ok;
        nxt = pop ? START : IDLE;
      end
      START: begin
        txd_c = 1'b0;
        nxt = wrap ? DATA : START;
      end
      DATA: begin
        txd_c = sh[0];
        nxt = !(wrap && last_bit) ? DATA : par == PAR_NONE ? STOP : PARITY;
      end
      PARITY: begin
        txd_c = par_bit;
        nxt = wrap ? STOP : PARITY;
      end
      STOP: nxt = wrap && (!stop2 || bit_cnt[0]) ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      par <= PAR_NONE;
      stop2 <= 1'b0;
      par_bit <= 1'b0;
      txd <= 1'b1;
      busy <= 1'b0;
    end else begin
      txd <= txd_c;
      busy <= state != IDLE;
      cnt <= (state == IDLE || wrap) ? '0 : cnt + CW'(1);
      if (pop) begin
        sh <= dout;
        par <= par_in;
        stop2 <= cfg_stop2;
        par_bit <= (^dout) ^ (par_in == PAR_ODD);
        bit_cnt <= '0;
      end else if (wrap && state == DATA) begin
        sh <= sh >> 1;
        bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
      end else if (wrap && state == STOP) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an in-house synchronous FIFO, replacing the vendor-FIFO-based transmitter path.
- Adds runtime-selectable parity (none/even/odd), 1 or 2 stop bits, configurable FIFO depth, a fill-level output and a busy flag.
- Sits between the CPU/MMIO store path and the board TXD pin.

Parameters:
- CLOCK_FREQUENCY, 32'd100_000_000, input clock in Hz.
- BAUD_RATE, 32'd115200, bit rate. DIVISOR = CLOCK_FREQUENCY/BAUD_RATE (integer, must be >= 2) is the clocks per bit.
- WORD_WIDTH, 32'd8, data bits per frame, legal 5..9.
- FIFO_DEPTH, 32'd16, FIFO entries, power of two, >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- din  input  WORD_WIDTH  word to enqueue
- we  input  1  write strobe
- full  output  1  FIFO holds FIFO_DEPTH words
- level  output  $clog2(FIFO_DEPTH)+1  words currently queued (excludes the word in flight)
- cfg_parity  input  2  00/11 none, 01 even, 10 odd
- cfg_stop2  input  1  1 = two stop bits
- busy  output  1  frame in progress
- txd  output  1  serial line, idle high

Behaviour:
- Reset values: txd=1, full=0, level=0, busy=0, FIFO empty, FSM IDLE, baud counter 0. Reset is asynchronous: asserting it mid-frame forces txd high immediately and discards the FIFO contents and the frame in flight.
- Write: accepted iff we && !full. A write while full is dropped silently; a pop in the same cycle does not rescue it.
- full and level are registered. They update on the edge after a push or pop. A simultaneous push and pop leaves level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, latch cfg_parity and cfg_stop2, go to START. The config is held constant for the whole frame.
  - START: txd=0 for DIVISOR cycles.
  - DATA: WORD_WIDTH bits, LSB first, DIVISOR cycles each.
  - PARITY (skipped when parity is none): even parity = XOR of the data bits; odd parity = its inverse.
  - STOP: txd=1 for DIVISOR cycles, or 2*DIVISOR when cfg_stop2. Then return to IDLE.
- Latency: if we is sampled at edge k into an empty FIFO with the FSM idle, the pop occurs at edge k+1 and txd falls at edge k+2. busy rises with the same edge as txd.
- Back-to-back frames: on the last stop cycle, if the FIFO is non-empty, the next start bit follows with exactly one IDLE cycle between frames (the pop cycle).
- busy is high from the start-bit edge through the end of the final stop bit.
- Baud counter: counts 0..DIVISOR-1, width $clog2(DIVISOR). A bit advances on wrap. The counter resets to 0 on entry to START.
- Bit counter: width $clog2(WORD_WIDTH+1); no wrap beyond WORD_WIDTH.

Optional Feature:
- Macro: UART_TX_CTS_EN.
- When defined:
  - Adds input cts_n (1 bit, active low), passed through a 2-flop synchroniser (reset to 1).
  - IDLE pops and starts a frame only while the synchronised cts_n=0.
  - Deasserting cts_n mid-frame never aborts that frame.
- When undefined: no port, and frames start as soon as data is available.

Decomposition:
- Package uart_pkg:
  - parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD)
  - tx_state_t enum
  - function calc_divisor(clock_frequency, baud_rate)
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH; ports clk, rst, din, we, full, dout, re, empty, level): registered flags, with pointer wrap through an extra MSB.
- The top level holds the baud/bit counters and the FSM.

Test Plan:
All scenarios use CLOCK_FREQUENCY=1_000_000, BAUD_RATE=250_000 (DIVISOR=4), WORD_WIDTH=8, FIFO_DEPTH=4.
- Single write 8'hA5, parity none, 1 stop -> txd low at edge k+2, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, high 4 cycles; busy high 40 cycles; level 1 then 0.
- Write 8'h03 with even parity, then 8'h03 with odd parity, 2 stop -> parity bits 0 then 1; stop phase 8 cycles; exactly one idle cycle between the frames.
- 6 consecutive writes while idle -> the first is popped, 4 are queued (full=1, level=4), the 6th is dropped; exactly 5 frames are emitted.
- Assert rst mid-DATA of a frame with 2 words queued -> txd=1 combinationally after the reset edge, busy=0, level=0; no further frames after release.
- Toggle cfg_parity and cfg_stop2 mid-frame -> the current frame keeps its latched config; the next frame uses the new config.
- With UART_TX_CTS_EN and cts_n=1, write 8'h55 -> txd stays high and level=1. Drop cts_n -> txd falls 4 edges later (2 sync + pop + start).
